// File: rtl/xbus_scheduler.sv
// X-bus scheduler: round-robin arbiter over the ifmap, fltr and psum requesters
// onto a single registered output bus, with per-grant burst limiting and
// out-of-range tag filtering.
module xbus_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rstn,          // active-high synchronous reset

  input  logic                      ifmap_valid,
  output logic                      ifmap_ready,
  input  logic [DATA_WIDTH-1:0]     ifmap_data,
  input  logic [ID_WIDTH-1:0]       ifmap_tag,
  input  logic                      ifmap_last,

  input  logic                      fltr_valid,
  output logic                      fltr_ready,
  input  logic [DATA_WIDTH-1:0]     fltr_data,
  input  logic [ID_WIDTH-1:0]       fltr_tag,
  input  logic                      fltr_last,

  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [2*DATA_WIDTH-1:0]   psum_data,
  input  logic [ID_WIDTH-1:0]       psum_tag,
  input  logic                      psum_last,

  input  logic [7:0]                cfg_burst_len,
  input  logic [2:0]                cfg_type_en,

  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic [2*DATA_WIDTH-1:0]   bus_data,
  output logic [1:0]                bus_type,
  output logic [ID_WIDTH-1:0]       bus_tag,

  output logic                      err_tag
);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  localparam logic [1:0]        TY_IFMAP   = 2'd0;
  localparam logic [1:0]        TY_FLTR    = 2'd1;
  localparam logic [1:0]        TY_PSUM    = 2'd2;
  localparam logic [ID_WIDTH:0] LP_NUM_COL = (ID_WIDTH+1)'(NUM_COL);

  // Round-robin successor: ifmap -> fltr -> psum -> ifmap.
  function automatic logic [1:0] f_next(input logic [1:0] t);
    return (t == TY_PSUM) ? TY_IFMAP : t + 2'd1;
  endfunction

  state_t                    r_state;
  state_t                    w_state_next;
  logic [1:0]                r_g;
  logic [1:0]                r_rr;
  logic [7:0]                r_cnt;
  logic [7:0]                r_blen;

  logic                      r_bus_valid;
  logic [2*DATA_WIDTH-1:0]   r_bus_data;
  logic [1:0]                r_bus_type;
  logic [ID_WIDTH-1:0]       r_bus_tag;
  logic                      r_err_tag;

  logic [3:0]                w_req;
  logic                      w_found;
  logic [1:0]                w_sel;
  logic [1:0]                w_cand;
  logic                      w_gvalid;
  logic [2*DATA_WIDTH-1:0]   w_gdata;
  logic [ID_WIDTH-1:0]       w_gtag;
  logic                      w_glast;
  logic                      w_slot_free;
  logic                      w_accept;
  logic                      w_tag_ok;
  logic                      w_burst_end;

  assign bus_valid = r_bus_valid;
  assign bus_data  = r_bus_data;
  assign bus_type  = r_bus_type;
  assign bus_tag   = r_bus_tag;
  assign err_tag   = r_err_tag;

  // Bit 3 is padding so a 2-bit type index never selects past the vector.
  assign w_req = {1'b0, psum_valid, fltr_valid, ifmap_valid} & {1'b0, cfg_type_en};

  // Pick the first enabled, valid requester at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr;
    w_cand  = r_rr;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!w_found && w_req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
      w_cand = f_next(w_cand);
    end
  end

  // Route the granted requester's beat; ifmap/fltr are zero-extended to psum width.
  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    w_gtag   = '0;
    w_glast  = 1'b0;
    case (r_g)
      TY_IFMAP: begin
        w_gvalid = ifmap_valid;
        w_gdata  = {{DATA_WIDTH{1'b0}}, ifmap_data};
        w_gtag   = ifmap_tag;
        w_glast  = ifmap_last;
      end
      TY_FLTR: begin
        w_gvalid = fltr_valid;
        w_gdata  = {{DATA_WIDTH{1'b0}}, fltr_data};
        w_gtag   = fltr_tag;
        w_glast  = fltr_last;
      end
      TY_PSUM: begin
        w_gvalid = psum_valid;
        w_gdata  = psum_data;
        w_gtag   = psum_tag;
        w_glast  = psum_last;
      end
      default: ;
    endcase
  end

  assign w_slot_free = !r_bus_valid || bus_ready;
  assign w_accept    = !rstn && (r_state == ST_XFER) && w_gvalid && w_slot_free;
  assign w_tag_ok    = ({1'b0, w_gtag} < LP_NUM_COL);
  assign w_burst_end = w_glast || (({1'b0, r_cnt} + 9'd1) == {1'b0, r_blen});

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: grant when something is requestable, release on burst end.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_next = ST_XFER;
      ST_XFER: if (w_accept && w_burst_end) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: only the granted requester sees ready, and only while the bus slot can take a beat.
  always_comb begin
    ifmap_ready = 1'b0;
    fltr_ready  = 1'b0;
    psum_ready  = 1'b0;
    if (!rstn && (r_state == ST_XFER)) begin
      case (r_g)
        TY_IFMAP: ifmap_ready = w_slot_free;
        TY_FLTR:  fltr_ready  = w_slot_free;
        TY_PSUM:  psum_ready  = w_slot_free;
        default: ;
      endcase
    end
  end

  // Grant, round-robin pointer, beat counter and burst length latched at grant time.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_g    <= TY_IFMAP;
      r_rr   <= TY_IFMAP;
      r_cnt  <= '0;
      r_blen <= 8'd1;
    end else if ((r_state == ST_IDLE) && w_found) begin
      r_g    <= w_sel;
      r_cnt  <= '0;
      r_blen <= (cfg_burst_len == 8'd0) ? 8'd1 : cfg_burst_len;
    end else if (w_accept) begin
      if (w_burst_end) begin
        r_cnt <= '0;
        r_rr  <= f_next(r_g);
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Output bus register: load on accept (bad tags are dropped but flagged), clear on drain.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_bus_type  <= '0;
      r_bus_tag   <= '0;
      r_err_tag   <= 1'b0;
    end else begin
      if (w_accept && w_tag_ok) begin
        r_bus_valid <= 1'b1;
        r_bus_data  <= w_gdata;
        r_bus_type  <= r_g;
        r_bus_tag   <= w_gtag;
      end else if (r_bus_valid && bus_ready) begin
        r_bus_valid <= 1'b0;
      end
      if (w_accept && !w_tag_ok) begin
        r_err_tag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xbus_scheduler.sv
// Self-checking bench for xbus_scheduler: cycle table for the basic round robin,
// directed corner sequences, and randomized traffic against a queue-level model.
module tb_xbus_scheduler;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            ifmap_valid, ifmap_ready, ifmap_last;
  logic [DW-1:0]   ifmap_data;
  logic [IW-1:0]   ifmap_tag;
  logic            fltr_valid, fltr_ready, fltr_last;
  logic [DW-1:0]   fltr_data;
  logic [IW-1:0]   fltr_tag;
  logic            psum_valid, psum_ready, psum_last;
  logic [2*DW-1:0] psum_data;
  logic [IW-1:0]   psum_tag;
  logic [7:0]      cfg_burst_len;
  logic [2:0]      cfg_type_en;
  logic            bus_valid, bus_ready;
  logic [2*DW-1:0] bus_data;
  logic [1:0]      bus_type;
  logic [IW-1:0]   bus_tag;
  logic            err_tag;

  xbus_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .ifmap_tag(ifmap_tag), .ifmap_last(ifmap_last),
    .fltr_valid(fltr_valid), .fltr_ready(fltr_ready), .fltr_data(fltr_data),
    .fltr_tag(fltr_tag), .fltr_last(fltr_last),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .psum_tag(psum_tag), .psum_last(psum_last),
    .cfg_burst_len(cfg_burst_len), .cfg_type_en(cfg_type_en),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data),
    .bus_type(bus_type), .bus_tag(bus_tag), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  tag_in;
    logic        exp_valid;
    logic [1:0]  exp_type;
    logic [3:0]  exp_tag;
    logic [31:0] exp_data;
    logic [2:0]  exp_rdy;   // {psum, fltr, ifmap}
  } vec_t;

  beat_t src[3][$];
  exp_t  exp_q[$];
  int    ptr[3];
  vec_t  tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn        = 1'b1;
    ifmap_valid = 1'b0;
    fltr_valid  = 1'b0;
    psum_valid  = 1'b0;
    bus_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
  endtask

  task automatic push_beat(input int t, input logic [31:0] d, input logic [3:0] tg, input logic l);
    beat_t b;
    b.data = d; b.tag = tg; b.last = l;
    src[t].push_back(b);
  endtask

  task automatic push_exp(input logic [1:0] ty, input logic [3:0] tg, input logic [31:0] d);
    exp_t e;
    e.typ = ty; e.tag = tg; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_all();
    for (int t = 0; t < 3; t++) src[t].delete();
    exp_q.delete();
  endtask

  task automatic drive_heads();
    ifmap_valid = (ptr[0] < src[0].size());
    fltr_valid  = (ptr[1] < src[1].size());
    psum_valid  = (ptr[2] < src[2].size());
    if (ifmap_valid) begin
      ifmap_data = src[0][ptr[0]].data[DW-1:0];
      ifmap_tag  = src[0][ptr[0]].tag;
      ifmap_last = src[0][ptr[0]].last;
    end
    if (fltr_valid) begin
      fltr_data = src[1][ptr[1]].data[DW-1:0];
      fltr_tag  = src[1][ptr[1]].tag;
      fltr_last = src[1][ptr[1]].last;
    end
    if (psum_valid) begin
      psum_data = src[2][ptr[2]].data;
      psum_tag  = src[2][ptr[2]].tag;
      psum_last = src[2][ptr[2]].last;
    end
  endtask

  // Transaction-level reference: walk the source queues in round-robin order,
  // taking up to max(blen,1) beats per grant or until a last beat.
  function automatic void build_model(input logic [7:0] blen, input logic [2:0] en, output logic err);
    int p[3];
    int rr = 0;
    int bl = (blen == 8'd0) ? 1 : int'(blen);
    err = 1'b0;
    exp_q.delete();
    for (int t = 0; t < 3; t++) p[t] = 0;
    forever begin
      int g = -1;
      int n = 0;
      beat_t b;
      for (int k = 0; k < 3; k++) begin
        int t = (rr + k) % 3;
        if (g < 0 && en[t] && p[t] < src[t].size()) g = t;
      end
      if (g < 0) break;
      do begin
        exp_t e;
        b = src[g][p[g]];
        p[g]++;
        n++;
        if (int'(b.tag) < NC) begin
          e.typ = 2'(g); e.tag = b.tag; e.data = b.data;
          exp_q.push_back(e);
        end else begin
          err = 1'b1;
        end
      end while (!b.last && n < bl && p[g] < src[g].size());
      rr = (g + 1) % 3;
    end
  endfunction

  // Present the source queues, collect bus beats, and compare them in order against exp_q.
  task automatic run_engine(input int ready_pct, input int budget, input logic [2:0] en);
    int oi = 0;
    bit done = 1'b0;
    logic [2:0] acc;
    for (int t = 0; t < 3; t++) ptr[t] = 0;
    drive_heads();
    bus_ready = (int'($urandom_range(0, 99)) < ready_pct);
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      acc = {psum_valid & psum_ready, fltr_valid & fltr_ready, ifmap_valid & ifmap_ready};
      if (bus_valid && bus_ready) begin
        if (oi < exp_q.size()) begin
          chk("beat_type", 64'(bus_type), 64'(exp_q[oi].typ));
          chk("beat_tag",  64'(bus_tag),  64'(exp_q[oi].tag));
          chk("beat_data", 64'(bus_data), 64'(exp_q[oi].data));
        end else begin
          chk("extra_beat", 64'(oi + 1), 64'(exp_q.size()));
        end
        oi++;
      end
      nxt();
      for (int t = 0; t < 3; t++) if (acc[t]) ptr[t]++;
      drive_heads();
      bus_ready = (int'($urandom_range(0, 99)) < ready_pct);
      done = !bus_valid;
      for (int t = 0; t < 3; t++) if (en[t] && ptr[t] < src[t].size()) done = 1'b0;
    end
    chk("drain_in_budget", 64'(done), 64'(1));
    chk("beat_total", 64'(oi), 64'(exp_q.size()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic exp_err;
    logic [2:0] en;
    logic [7:0] blen;
    logic [15:0] dd[4];
    int k;
    int oi;
    logic acc;

    ifmap_data = '0; ifmap_tag = '0; ifmap_last = 1'b0;
    fltr_data = '0; fltr_tag = '0; fltr_last = 1'b0;
    psum_data = '0; psum_tag = '0; psum_last = 1'b0;
    cfg_burst_len = 8'd1; cfg_type_en = 3'b111; bus_ready = 1'b1;

    // Reset state with every requester pushing.
    rstn = 1'b1;
    ifmap_valid = 1'b1; fltr_valid = 1'b1; psum_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_valid", 64'(bus_valid), 64'(0));
    chk("rst_bus_data",  64'(bus_data),  64'(0));
    chk("rst_bus_type",  64'(bus_type),  64'(0));
    chk("rst_bus_tag",   64'(bus_tag),   64'(0));
    chk("rst_err_tag",   64'(err_tag),   64'(0));
    chk("rst_readies",   64'({psum_ready, fltr_ready, ifmap_ready}), 64'(0));

    // Round robin, burst of 2, all requesters valid, bus always ready.
    tbl[0]  = '{4'd0, 1'b0, 2'd0, 4'd0, 32'h0,        3'b000};
    tbl[1]  = '{4'd1, 1'b0, 2'd0, 4'd0, 32'h0,        3'b001};
    tbl[2]  = '{4'd2, 1'b1, 2'd0, 4'd1, 32'h1111,     3'b001};
    tbl[3]  = '{4'd3, 1'b1, 2'd0, 4'd2, 32'h1111,     3'b000};
    tbl[4]  = '{4'd0, 1'b0, 2'd0, 4'd0, 32'h0,        3'b010};
    tbl[5]  = '{4'd1, 1'b1, 2'd1, 4'd0, 32'h2222,     3'b010};
    tbl[6]  = '{4'd2, 1'b1, 2'd1, 4'd1, 32'h2222,     3'b000};
    tbl[7]  = '{4'd3, 1'b0, 2'd0, 4'd0, 32'h0,        3'b100};
    tbl[8]  = '{4'd0, 1'b1, 2'd2, 4'd3, 32'h33333333, 3'b100};
    tbl[9]  = '{4'd1, 1'b1, 2'd2, 4'd0, 32'h33333333, 3'b000};
    tbl[10] = '{4'd2, 1'b0, 2'd0, 4'd0, 32'h0,        3'b001};
    do_reset();
    cfg_type_en = 3'b111; cfg_burst_len = 8'd2; bus_ready = 1'b1;
    ifmap_valid = 1'b1; fltr_valid = 1'b1; psum_valid = 1'b1;
    ifmap_last = 1'b0; fltr_last = 1'b0; psum_last = 1'b0;
    ifmap_data = 16'h1111; fltr_data = 16'h2222; psum_data = 32'h33333333;
    for (int r = 0; r < 11; r++) begin
      ifmap_tag = tbl[r].tag_in; fltr_tag = tbl[r].tag_in; psum_tag = tbl[r].tag_in;
      @(negedge clk);
      chk("rr_bus_valid", 64'(bus_valid), 64'(tbl[r].exp_valid));
      if (tbl[r].exp_valid) begin
        chk("rr_bus_type", 64'(bus_type), 64'(tbl[r].exp_type));
        chk("rr_bus_tag",  64'(bus_tag),  64'(tbl[r].exp_tag));
        chk("rr_bus_data", 64'(bus_data), 64'(tbl[r].exp_data));
      end
      chk("rr_readies", 64'({psum_ready, fltr_ready, ifmap_ready}), 64'(tbl[r].exp_rdy));
      nxt();
    end

    // Stall: ifmap burst of 4, bus_ready low for 3 cycles after the first beat appears.
    do_reset();
    cfg_type_en = 3'b001; cfg_burst_len = 8'd4;
    for (int i = 0; i < 4; i++) dd[i] = 16'hD000 + 16'(i);
    k = 0; oi = 0;
    for (int c = 0; c < 15; c++) begin
      bus_ready   = !(c >= 2 && c <= 4);
      ifmap_valid = (k < 4);
      ifmap_data  = dd[k < 4 ? k : 3];
      ifmap_last  = (k == 3);
      ifmap_tag   = 4'd1;
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        chk("stall_ifmap_ready", 64'(ifmap_ready), 64'(0));
        chk("stall_bus_valid",   64'(bus_valid),   64'(1));
        chk("stall_bus_data",    64'(bus_data),    64'(dd[0]));
      end
      acc = ifmap_valid && ifmap_ready;
      if (bus_valid && bus_ready) begin
        chk("stall_beat_data", 64'(bus_data), 64'(dd[oi < 4 ? oi : 3]));
        oi++;
      end
      nxt();
      if (acc) k++;
    end
    chk("stall_beats_out", 64'(oi), 64'(4));
    chk("stall_beats_in",  64'(k),  64'(4));

    // last on beat 2 with burst 8: grant ends early and fltr is next.
    do_reset();
    clear_all();
    cfg_type_en = 3'b111; cfg_burst_len = 8'd8;
    push_beat(0, 32'h0A01, 4'd0, 1'b0); push_beat(0, 32'h0A02, 4'd1, 1'b1);
    push_beat(0, 32'h0A03, 4'd2, 1'b0); push_beat(0, 32'h0A04, 4'd3, 1'b1);
    push_beat(1, 32'h0B01, 4'd2, 1'b1);
    push_beat(2, 32'hC0000C01, 4'd3, 1'b1);
    push_exp(2'd0, 4'd0, 32'h0A01); push_exp(2'd0, 4'd1, 32'h0A02);
    push_exp(2'd1, 4'd2, 32'h0B01); push_exp(2'd2, 4'd3, 32'hC0000C01);
    push_exp(2'd0, 4'd2, 32'h0A03); push_exp(2'd0, 4'd3, 32'h0A04);
    run_engine(100, 200, 3'b111);

    // burst length 0 behaves as 1 beat per grant.
    do_reset();
    clear_all();
    cfg_type_en = 3'b111; cfg_burst_len = 8'd0;
    push_beat(0, 32'h0A11, 4'd0, 1'b0); push_beat(0, 32'h0A12, 4'd1, 1'b1);
    push_beat(1, 32'h0B11, 4'd2, 1'b0); push_beat(1, 32'h0B12, 4'd3, 1'b1);
    push_beat(2, 32'hC0000C11, 4'd0, 1'b1);
    push_exp(2'd0, 4'd0, 32'h0A11); push_exp(2'd1, 4'd2, 32'h0B11);
    push_exp(2'd2, 4'd0, 32'hC0000C11); push_exp(2'd0, 4'd1, 32'h0A12);
    push_exp(2'd1, 4'd3, 32'h0B12);
    run_engine(100, 200, 3'b111);

    // Out-of-range psum tag: dropped, still counted in the burst, sticky error.
    do_reset();
    clear_all();
    cfg_type_en = 3'b101; cfg_burst_len = 8'd2;
    push_beat(0, 32'h0A21, 4'd0, 1'b1); push_beat(0, 32'h0A22, 4'd1, 1'b1);
    push_beat(2, 32'hBAD00005, 4'd5, 1'b0);
    push_beat(2, 32'hC0000C21, 4'd2, 1'b0);
    push_beat(2, 32'hC0000C22, 4'd3, 1'b1);
    push_exp(2'd0, 4'd0, 32'h0A21); push_exp(2'd2, 4'd2, 32'hC0000C21);
    push_exp(2'd0, 4'd1, 32'h0A22); push_exp(2'd2, 4'd3, 32'hC0000C22);
    run_engine(100, 200, 3'b101);
    chk("badtag_err_set", 64'(err_tag), 64'(1));
    repeat (3) nxt();
    @(negedge clk);
    chk("badtag_err_sticky", 64'(err_tag), 64'(1));
    do_reset();
    @(negedge clk);
    chk("badtag_err_cleared", 64'(err_tag), 64'(0));

    // Reset in the middle of a fltr burst with a beat pending on the bus.
    do_reset();
    cfg_type_en = 3'b011; cfg_burst_len = 8'd4; bus_ready = 1'b1;
    ifmap_valid = 1'b1; ifmap_last = 1'b1; ifmap_data = 16'h00AA; ifmap_tag = 4'd0;
    fltr_valid = 1'b0; psum_valid = 1'b0;
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("mid_rst_ifmap_ready", 64'(ifmap_ready), 64'(1));
    nxt();
    ifmap_valid = 1'b0;
    fltr_valid = 1'b1; fltr_last = 1'b0; fltr_data = 16'h00BB; fltr_tag = 4'd1;
    nxt();
    nxt();
    bus_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_pending_valid", 64'(bus_valid), 64'(1));
    chk("mid_rst_pending_type",  64'(bus_type),  64'(1));
    nxt();
    rstn = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_gated", 64'({psum_ready, fltr_ready, ifmap_ready}), 64'(0));
    nxt();
    @(negedge clk);
    chk("mid_rst_bus_valid", 64'(bus_valid), 64'(0));
    chk("mid_rst_bus_data",  64'(bus_data),  64'(0));
    chk("mid_rst_bus_type",  64'(bus_type),  64'(0));
    nxt();
    rstn = 1'b0; cfg_type_en = 3'b111;
    ifmap_valid = 1'b1; ifmap_last = 1'b0; fltr_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle_readies", 64'({fltr_ready, ifmap_ready}), 64'(0));
    nxt();
    @(negedge clk);
    chk("mid_rst_rr_ifmap_ready", 64'(ifmap_ready), 64'(1));
    chk("mid_rst_rr_fltr_ready",  64'(fltr_ready),  64'(0));

    // Randomized traffic against the queue-level model.
    for (int run = 0; run < 16; run++) begin
      do_reset();
      clear_all();
      en   = 3'($urandom_range(1, 7));
      blen = 8'($urandom_range(0, 5));
      cfg_type_en = en; cfg_burst_len = blen;
      for (int t = 0; t < 3; t++) begin
        int n = int'($urandom_range(1, 8));
        for (int i = 0; i < n; i++) begin
          logic [31:0] d = (t == 2) ? 32'($urandom) : {16'h0, 16'($urandom)};
          push_beat(t, d, 4'($urandom_range(0, 4)), (i == n - 1) || ($urandom_range(0, 4) == 0));
        end
      end
      build_model(blen, en, exp_err);
      run_engine(int'($urandom_range(40, 100)), 400, en);
      chk("rand_err_tag", 64'(err_tag), 64'(exp_err));
      for (int t = 0; t < 3; t++) begin
        if (!en[t]) chk("rand_disabled_untouched", 64'(ptr[t]), 64'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xbus_scheduler.md
XBUS_SCHEDULER -- requirements
Module: xbus_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning ifmap/fltr word width; psum width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter NUM_COL, default 4, meaning number of PE columns addressable on the X-bus.
REQ-003 SHALL have parameter ID_WIDTH, default 4, meaning tag/ID field width; NUM_COL <= 2^ID_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  synchronous, active-high reset (asserted = 1, sampled on clk).
REQ-006 SHALL have ports ifmap_valid/ifmap_ready  input/output  1  ifmap requester handshake; ifmap_data  input  DATA_WIDTH; ifmap_tag  input  ID_WIDTH; ifmap_last  input  1.
REQ-007 SHALL have ports fltr_valid/fltr_ready, fltr_data, fltr_tag, fltr_last, same widths and directions as ifmap.
REQ-008 SHALL have ports psum_valid/psum_ready, psum_data  input  2*DATA_WIDTH, psum_tag, psum_last, same otherwise.
REQ-009 SHALL have port cfg_burst_len  input  8  maximum beats per grant; 0 treated as 1.
REQ-010 SHALL have port cfg_type_en  input  3  per-type enable, bit0 ifmap, bit1 fltr, bit2 psum.
REQ-011 SHALL have ports bus_valid  output  1; bus_ready  input  1; bus_data  output  2*DATA_WIDTH (ifmap/fltr zero-extended); bus_type  output  2 (0 ifmap, 1 fltr, 2 psum); bus_tag  output  ID_WIDTH.
REQ-012 SHALL have port err_tag  output  1  sticky flag, out-of-range tag seen.

Function
REQ-013 SHALL implement FSM states IDLE and XFER, with grant register g (2 bits) and round-robin pointer rr (order ifmap->fltr->psum->ifmap).
REQ-014 In IDLE, SHALL select the first type at or after rr with valid=1 and cfg_type_en=1, latch it into g, clear beat counter, and enter XFER next cycle; stay IDLE if none.
REQ-015 In IDLE, all *_ready SHALL be 0.
REQ-016 In XFER, only the granted requester's ready SHALL be driven, equal to (!bus_valid || bus_ready); others 0.
REQ-017 An accepted beat (valid&&ready) SHALL load bus_data/bus_type/bus_tag and set bus_valid on the next clock edge (latency 1 cycle).
REQ-018 bus_valid SHALL hold, with bus_data/type/tag stable, until bus_valid&&bus_ready; it then clears unless a new beat is loaded the same cycle (full throughput, 1 beat/cycle).
REQ-019 The beat counter SHALL increment per accepted beat; XFER->IDLE occurs after the accepted beat with last=1, or with count+1 == max(cfg_burst_len,1), whichever comes first.
REQ-020 On XFER->IDLE, rr SHALL become g+1 mod 3; minimum one IDLE bubble cycle between grants.
REQ-021 If the granted requester drops valid in XFER, the grant SHALL be held (no timeout).
REQ-022 An accepted beat with tag >= NUM_COL SHALL be consumed and counted but not placed on the bus; err_tag sets to 1 and stays until reset.
REQ-023 Clearing a cfg_type_en bit during XFER SHALL NOT abort the current grant; it only affects later IDLE selections.
REQ-024 cfg_burst_len SHALL be sampled at the grant cycle and held for the whole burst.

Reset
REQ-025 While rstn=1, SHALL reset: state=IDLE, g=0, rr=0 (ifmap), beat counter=0, bus_valid=0, bus_data=0, bus_type=0, bus_tag=0, err_tag=0, all *_ready=0.
REQ-026 Reset mid-burst SHALL discard any pending bus beat in the next cycle, without completing it.

Verification
REQ-027 Bench SHALL check: all three valid, cfg_burst_len=2, cfg_type_en=3'b111, bus_ready=1, tags 0..3 -> bus_type sequence 0,0,1,1,2,2 with one bubble between bursts.
REQ-028 Bench SHALL check: ifmap burst of 4 with bus_ready low for 3 cycles after the first beat -> bus_data frozen, ifmap_ready=0 during the stall, no beat lost or duplicated.
REQ-029 Bench SHALL check: ifmap_last=1 on beat 2 with cfg_burst_len=8 -> grant ends after 2 beats and rr points to fltr.
REQ-030 Bench SHALL check: psum_tag=5 with NUM_COL=4 -> beat consumed, no bus_valid for it, err_tag=1 until reset.
REQ-031 Bench SHALL check: cfg_burst_len=0 -> each grant carries exactly 1 beat.
REQ-032 Bench SHALL check: rstn asserted during a fltr burst with bus_valid=1 -> next cycle bus_valid=0, state IDLE, rr=ifmap.
